// File: rtl/alu_cmd_sequencer_if.sv
// ============================================================================
// Module : alu_cmd_sequencer_if
// Brief  : Command and result handshake channels of the ALU command sequencer
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface alu_cmd_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [OP_W-1:0]   cmd_op;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W:0]   res_data;
    logic [OP_W-1:0]   res_op;
    logic              res_illegal;

    // master: command producer / result consumer
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
        input  cmd_ready, res_valid, res_data, res_op, res_illegal
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
        output cmd_ready, res_valid, res_data, res_op, res_illegal
    );
endinterface

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// Module : alu_cmd_sequencer
// Brief  : Command FIFO feeding a combinational ALU, result in a valid/ready slot
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_cmd_sequencer #(
    parameter int DATA_W     = 16,
    parameter int OP_W       = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  wire                          clk,
    input  wire                          rst_n,
    alu_cmd_sequencer_if.slave           bus,
    output logic [DATA_W-1:0]            alu_num1,
    output logic [DATA_W-1:0]            alu_num2,
    output logic [OP_W-1:0]              alu_sel,
    input  wire  [DATA_W:0]              alu_result,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_depth        = CNT_W'(FIFO_DEPTH);
    localparam logic [OP_W-1:0]  c_max_legal_op = OP_W'(4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    logic [DATA_W-1:0] r_mem_a  [FIFO_DEPTH];
    logic [DATA_W-1:0] r_mem_b  [FIFO_DEPTH];
    logic [OP_W-1:0]   r_mem_op [FIFO_DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              r_res_valid;
    logic [DATA_W:0]   r_res_data;
    logic [OP_W-1:0]   r_res_op;
    logic              r_res_illegal;

    logic              w_empty;
    logic              w_cmd_ready;
    logic              w_slot_free;
    logic              w_push;
    logic              w_pop;
    logic [OP_W-1:0]   w_head_op;
    state_t            w_state;

    assign w_empty     = (r_count == '0);
    assign w_cmd_ready = (r_count < c_depth);
    assign w_slot_free = !r_res_valid || bus.res_ready;
    assign w_push      = bus.cmd_valid && w_cmd_ready;
    assign w_head_op   = r_mem_op[r_rd_ptr];

    // State is a pure function of occupancy and the result slot, so it needs no register of its own
    always_comb begin
        w_state = S_IDLE;
        if (!w_empty) begin
            w_state = w_slot_free ? S_ISSUE : S_HOLD;
        end else if (r_res_valid) begin
            w_state = S_DRAIN;
        end
    end

    assign w_pop = (w_state == S_ISSUE);

    always_comb begin
        alu_num1 = '0;
        alu_num2 = '0;
        alu_sel  = '0;
        if (!w_empty) begin
            alu_num1 = r_mem_a[r_rd_ptr];
            alu_num2 = r_mem_b[r_rd_ptr];
            alu_sel  = w_head_op;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are meaningful
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]  <= bus.cmd_a;
            r_mem_b[r_wr_ptr]  <= bus.cmd_b;
            r_mem_op[r_wr_ptr] <= bus.cmd_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_op      <= '0;
            r_res_illegal <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            case (w_state)
                S_ISSUE: begin
                    r_res_valid   <= 1'b1;
                    r_res_data    <= alu_result;
                    r_res_op      <= w_head_op;
                    r_res_illegal <= (w_head_op > c_max_legal_op);
                end
                S_DRAIN: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_data    = r_res_data;
    assign bus.res_op      = r_res_op;
    assign bus.res_illegal = r_res_illegal;
    assign fifo_count      = r_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
// Module : tb_alu_cmd_sequencer
// Brief  : Self-checking bench for alu_cmd_sequencer with an ALU model and scoreboard
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_cmd_sequencer;

    localparam int DATA_W     = 16;
    localparam int OP_W       = 3;
    localparam int FIFO_DEPTH = 4;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic [DATA_W-1:0] alu_num1;
    logic [DATA_W-1:0] alu_num2;
    logic [OP_W-1:0]   alu_sel;
    logic [DATA_W:0]   alu_result;
    logic [2:0]        fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [DATA_W:0] res;
        logic [OP_W-1:0] op;
    } exp_t;

    exp_t q[$];

    alu_cmd_sequencer_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

    alu_cmd_sequencer #(
        .DATA_W     (DATA_W),
        .OP_W       (OP_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_num1   (alu_num1),
        .alu_num2   (alu_num2),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // 17-bit ALU semantics; unknown opcodes fall through to AND
    function automatic logic [DATA_W:0] alu_ref(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [OP_W-1:0]   op);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            default: return {1'b0, a & b};
        endcase
    endfunction

    assign alu_result = alu_ref(alu_num1, alu_num2, alu_sel);

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_op    = '0;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst_n = 1'b0;
        #2;
        n_checks++;
        if (fifo_count !== 3'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        n_checks++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== '0 || bus.res_op !== '0 || bus.res_illegal !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_slot: got v=%b d=%h op=%0d ill=%b expected all 0",
                     bus.res_valid, bus.res_data, bus.res_op, bus.res_illegal);
        end
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
        n_checks++;
        if (alu_sel !== 3'd0 || alu_num1 !== '0 || alu_num2 !== '0) begin
            n_errors++;
            $display("FAIL reset_alu_drive: got %h/%h/%0d expected 0/0/0", alu_num1, alu_num2, alu_sel);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: got ready=%b valid=%b expected 1/0", bus.cmd_ready, bus.res_valid);
        end
    endtask

    task automatic test_single(input string name, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                               input logic [OP_W-1:0] op, input logic [DATA_W:0] exp_data, input logic exp_ill);
        bus.res_ready = 1'b0;
        n_checks++;
        if (alu_num1 !== '0 || alu_num2 !== '0 || alu_sel !== '0) begin
            n_errors++;
            $display("FAIL %s empty_drive: got %h/%h/%0d expected 0/0/0", name, alu_num1, alu_num2, alu_sel);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        tick();
        bus.cmd_valid = 1'b0;
        n_checks++;
        if (bus.res_valid !== 1'b0 || alu_sel !== op || alu_num1 !== a || alu_num2 !== b) begin
            n_errors++;
            $display("FAIL %s head: got valid=%b drive=%h/%h/%0d expected valid=0 drive=%h/%h/%0d",
                     name, bus.res_valid, alu_num1, alu_num2, alu_sel, a, b, op);
        end
        tick();
        n_checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== exp_data || bus.res_op !== op || bus.res_illegal !== exp_ill) begin
            n_errors++;
            $display("FAIL %s result: got v=%b d=%h op=%0d ill=%b expected v=1 d=%h op=%0d ill=%b",
                     name, bus.res_valid, bus.res_data, bus.res_op, bus.res_illegal, exp_data, op, exp_ill);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        n_checks++;
        if (bus.res_valid !== 1'b0 || fifo_count !== 3'd0) begin
            n_errors++;
            $display("FAIL %s drain: got valid=%b count=%0d expected 0/0", name, bus.res_valid, fifo_count);
        end
    endtask

    task automatic test_backpressure();
        int   sent = 0;
        int   cycles = 0;
        exp_t e;
        logic [DATA_W:0] held;
        bus.res_ready = 1'b0;
        while (sent < 5 && cycles < 20) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_a     = DATA_W'($urandom);
            bus.cmd_b     = DATA_W'($urandom);
            bus.cmd_op    = OP_W'($urandom_range(7));
            if (bus.cmd_ready) begin
                q.push_back('{res: alu_ref(bus.cmd_a, bus.cmd_b, bus.cmd_op), op: bus.cmd_op});
                sent++;
            end
            tick();
            cycles++;
        end
        n_checks++;
        if (sent != 5) begin n_errors++; $display("FAIL bp_fill: got %0d accepted expected 5", sent); end
        // Keep offering a command while full: it must not be taken
        bus.cmd_a = 16'hDEAD;
        held      = bus.res_data;
        n_checks++;
        if (fifo_count !== 3'd4 || bus.cmd_ready !== 1'b0 || bus.res_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_full: got count=%0d ready=%b valid=%b expected 4/0/1", fifo_count, bus.cmd_ready, bus.res_valid);
        end
        repeat (3) begin
            tick();
            n_checks++;
            if (fifo_count !== 3'd4 || bus.res_valid !== 1'b1 || bus.res_data !== held) begin
                n_errors++;
                $display("FAIL bp_hold: got count=%0d valid=%b data=%h expected 4/1/%h", fifo_count, bus.res_valid, bus.res_data, held);
            end
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (q.size() == 0) begin
                n_errors++;
                $display("FAIL bp_drain: got result with empty scoreboard expected none");
            end else begin
                e = q.pop_front();
                if (bus.res_valid !== 1'b1 || bus.res_data !== e.res || bus.res_op !== e.op) begin
                    n_errors++;
                    $display("FAIL bp_drain[%0d]: got v=%b d=%h op=%0d expected v=1 d=%h op=%0d",
                             k, bus.res_valid, bus.res_data, bus.res_op, e.res, e.op);
                end
            end
            tick();
        end
        bus.res_ready = 1'b0;
        n_checks++;
        if (bus.res_valid !== 1'b0 || fifo_count !== 3'd0) begin
            n_errors++;
            $display("FAIL bp_empty: got valid=%b count=%0d expected 0/0", bus.res_valid, fifo_count);
        end
    endtask

    task automatic run_traffic(input string name, input int n, input int vpct, input int rpct, input bit check_rate);
        int   sent = 0;
        int   got = 0;
        int   cycles = 0;
        int   gaps = 0;
        int   in_flight = 0;
        bit   started = 1'b0;
        bit   hold = 1'b0;
        logic [DATA_W:0] hd = '0;
        logic [OP_W-1:0] hop = '0;
        exp_t e;
        bus.cmd_valid = 1'b0;
        while (got < n && cycles < 40 * n + 100) begin
            if (hold) begin
                n_checks++;
                if (bus.res_valid !== 1'b1 || bus.res_data !== hd || bus.res_op !== hop) begin
                    n_errors++;
                    $display("FAIL %s stable: got v=%b d=%h op=%0d expected v=1 d=%h op=%0d",
                             name, bus.res_valid, bus.res_data, bus.res_op, hd, hop);
                end
            end
            n_checks++;
            if (int'(fifo_count) + int'(bus.res_valid) != in_flight) begin
                n_errors++;
                $display("FAIL %s occupancy: got %0d+%0d expected %0d in flight", name, fifo_count, bus.res_valid, in_flight);
            end
            if (bus.res_valid) started = 1'b1;
            if (started && !bus.res_valid) gaps++;

            // A refused command stays on the bus unchanged; otherwise draw a new one
            if (!(bus.cmd_valid && !bus.cmd_ready)) begin
                bus.cmd_valid = (sent < n) && ($urandom_range(99) < vpct);
                bus.cmd_a     = DATA_W'($urandom);
                bus.cmd_b     = DATA_W'($urandom);
                bus.cmd_op    = OP_W'($urandom_range(7));
            end
            bus.res_ready = ($urandom_range(99) < rpct);

            if (bus.res_valid && bus.res_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++;
                    $display("FAIL %s extra: got d=%h expected no result", name, bus.res_data);
                end else begin
                    e = q.pop_front();
                    if (bus.res_data !== e.res || bus.res_op !== e.op || bus.res_illegal !== (e.op > 3'd4)) begin
                        n_errors++;
                        $display("FAIL %s result[%0d]: got d=%h op=%0d ill=%b expected d=%h op=%0d ill=%b",
                                 name, got, bus.res_data, bus.res_op, bus.res_illegal, e.res, e.op, (e.op > 3'd4));
                    end
                end
                got++;
                in_flight--;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                q.push_back('{res: alu_ref(bus.cmd_a, bus.cmd_b, bus.cmd_op), op: bus.cmd_op});
                sent++;
                in_flight++;
            end
            hold = bus.res_valid && !bus.res_ready;
            hd   = bus.res_data;
            hop  = bus.res_op;
            tick();
            cycles++;
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        n_checks++;
        if (got != n || q.size() != 0) begin
            n_errors++;
            $display("FAIL %s complete: got %0d results, %0d left expected %0d results, 0 left", name, got, q.size(), n);
        end
        if (check_rate) begin
            n_checks++;
            if (gaps != 0 || cycles != n + 2) begin
                n_errors++;
                $display("FAIL %s rate: got %0d gaps in %0d cycles expected 0 gaps in %0d cycles", name, gaps, cycles, n + 2);
            end
        end
        q.delete();
    endtask

    task automatic test_reset_midstream();
        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_a     = DATA_W'($urandom);
            bus.cmd_b     = DATA_W'($urandom);
            bus.cmd_op    = 3'b011;
            tick();
        end
        bus.cmd_valid = 1'b0;
        n_checks++;
        if (fifo_count !== 3'd3 || bus.res_valid !== 1'b1 || alu_sel !== 3'b011) begin
            n_errors++;
            $display("FAIL midrst_setup: got count=%0d valid=%b sel=%0d expected 3/1/3", fifo_count, bus.res_valid, alu_sel);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (fifo_count !== 3'd0 || bus.res_valid !== 1'b0 || alu_sel !== 3'd0 || bus.cmd_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_async: got count=%0d valid=%b sel=%0d ready=%b expected 0/0/0/1",
                     fifo_count, bus.res_valid, alu_sel, bus.cmd_ready);
        end
        tick();
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        repeat (4) begin
            tick();
            n_checks++;
            if (bus.res_valid !== 1'b0 || fifo_count !== 3'd0) begin
                n_errors++;
                $display("FAIL midrst_stale: got valid=%b count=%0d expected 0/0", bus.res_valid, fifo_count);
            end
        end
        bus.res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single("single_add", 16'hFFFF, 16'h0001, 3'b000, 17'h10000, 1'b0);
        test_single("sub_wrap",   16'h0003, 16'h0005, 3'b001, 17'h1FFFE, 1'b0);
        test_single("illegal_op", 16'h00F0, 16'h0FF0, 3'b110, 17'h000F0, 1'b1);
        test_backpressure();
        run_traffic("streaming", 100, 100, 100, 1'b1);
        run_traffic("random",    200,  60,  50, 1'b0);
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
